ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the EX-stage operands and operation for MULT/MULTU/DIV/DIVU, runs a 32-iteration shift-add or restoring-divide sequence, and owns the architectural HI/LO registers. While an operation is in flight it raises a stall request so the hazard logic freezes IF/ID/EX.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 31 +++
 rtl/ex_muldiv_unit.sv | 129 ++++++++++++
 tb/tb_ex_muldiv_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } muldiv_state_t;

    localparam logic [31:0] DIVZERO_QUOTIENT = '1;

    function automatic logic opIsDiv(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic opIsSigned(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               isDiv,
    output logic [2*WIDTH-1:0] accNext,
    output logic               qBit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        qBit    = 1'b0;
        accNext = '0;
        if (isDiv) begin
            // Remainder stays below the divisor, so bit WIDTH of diff is a pure borrow flag.
            qBit    = ~diff[WIDTH];
            accNext = {(qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end else begin
            accNext = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with pipeline stall request.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_en,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    muldiv_state_t      state;
    logic [1:0]         opReg;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   aOrig;
    logic               negRes;
    logic               negRem;

    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic               inSigned;
    logic               inDiv;
    logic [2*WIDTH-1:0] accNext;
    logic               qBit;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;

    muldiv_step #(.WIDTH(WIDTH)) stepInst (
        .acc     (acc),
        .operand (operand),
        .isDiv   (opIsDiv(opReg)),
        .accNext (accNext),
        .qBit    (qBit)
    );

    always_comb begin
        inSigned = opIsSigned(op);
        inDiv    = opIsDiv(op);
        absA     = (inSigned && a[WIDTH-1]) ? -a : a;
        absB     = (inSigned && b[WIDTH-1]) ? -b : b;
        stall    = busy || (state == S_IDLE && start && !done);
    end

    always_comb begin
        prod  = negRes ? -acc : acc;
        resHi = prod[2*WIDTH-1:WIDTH];
        resLo = prod[WIDTH-1:0];
        if (opIsDiv(opReg)) begin
            if (operand == '0) begin
                resHi = aOrig;
                resLo = DIVZERO_QUOTIENT[WIDTH-1:0];
            end else begin
                resHi = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                resLo = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            opReg   <= OP_MULT;
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            aOrig   <= '0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (cpu_en) begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    // The done cycle still shows the finished instruction's start; skip it.
                    if (start && !done) begin
                        opReg   <= op;
                        acc     <= {{WIDTH{1'b0}}, (inDiv ? absA : absB)};
                        operand <= inDiv ? absB : absA;
                        aOrig   <= a;
                        negRes  <= inSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
                        negRem  <= inSigned && a[WIDTH-1];
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= opIsDiv(opReg) ? {accNext[2*WIDTH-1:1], qBit} : accNext;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_FIX: begin
                    hi    <= resHi;
                    lo    <= resLo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random ops vs. an arithmetic model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int nChecks = 0;
    int nPass   = 0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .cpu_en (cpu_en),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Returns {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int          sx;
        int          sy;
        longint      sp;
        logic [63:0] up;
        logic [31:0] q;
        logic [31:0] r;
        sx = x;
        sy = y;
        case (o)
            2'd0: begin sp = longint'(sx) * longint'(sy); return sp; end
            2'd1: begin up = {32'b0, x} * {32'b0, y}; return up; end
            2'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic doOp(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit holdAfter, input int pauseAt, input int mtloAt);
        int          stallCnt;
        bit          got;
        logic [63:0] exp;
        logic        busySnap;
        logic [31:0] hiSnap;
        logic [31:0] loSnap;
        logic [31:0] loBefore;
        exp      = model(o, x, y);
        op       = o;
        a        = x;
        b        = y;
        start    = 1'b1;
        stallCnt = 0;
        got      = 1'b0;
        loBefore = lo;
        for (int i = 0; i < 300 && !got; i++) begin
            if (i == pauseAt) begin
                busySnap = busy;
                hiSnap   = hi;
                loSnap   = lo;
                cpu_en   = 1'b0;
                repeat (5) begin
                    #1;
                    if (stall) stallCnt++;
                    @(negedge clk);
                end
                chk({tag, " pause busy"}, busy, busySnap);
                chk({tag, " pause hi"}, hi, hiSnap);
                chk({tag, " pause lo"}, lo, loSnap);
                cpu_en = 1'b1;
            end
            if (i == mtloAt) begin
                lo_we = 1'b1;
                wdata = 32'h5A5A_0F0F;
            end
            if (mtloAt >= 0 && i == mtloAt + 3) begin
                chk({tag, " mtlo in calc"}, lo, loBefore);
                lo_we = 1'b0;
            end
            #1;
            if (stall) stallCnt++;
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk({tag, " done seen"}, got, 1'b1);
        chk({tag, " stall cycles"}, stallCnt, (pauseAt >= 0) ? 39 : 34);
        chk({tag, " hi"}, hi, exp[63:32]);
        chk({tag, " lo"}, lo, exp[31:0]);
        chk({tag, " stall in done"}, stall, 1'b0);
        if (!holdAfter) start = 1'b0;
        @(negedge clk);
        chk({tag, " done pulse"}, done, 1'b0);
        chk({tag, " one op"}, busy, 1'b0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        bit          sawDone;

        rst    = 1'b1;
        cpu_en = 1'b1;
        start  = 1'b0;
        op     = 2'd0;
        a      = '0;
        b      = '0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset stall", stall, 0);

        hi_we = 1'b1;
        wdata = 32'hAAAA_5555;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi", hi, 32'hAAAA_5555);
        lo_we = 1'b1;
        wdata = 32'h1234_0000;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo", lo, 32'h1234_0000);

        doOp("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, -1);
        doOp("mult -3*5", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, -1, -1);
        doOp("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, -1);
        doOp("divu by 0", 2'd3, 32'h1234_5678, 32'd0, 1'b0, -1, -1);
        doOp("div by 0", 2'd2, 32'h8765_4321, 32'd0, 1'b0, -1, -1);
        doOp("div ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, -1);
        doOp("mult mtlo", 2'd0, 32'h0001_0003, 32'hFFFF_0007, 1'b0, -1, 5);

        doOp("hold first", 2'd0, 32'd1234, 32'd5678, 1'b1, -1, -1);
        doOp("divu 100/7", 2'd3, 32'd100, 32'd7, 1'b0, -1, -1);

        doOp("pause", 2'd2, 32'h7FFF_1234, 32'hFFFF_FF03, 1'b0, 10, -1);

        op    = 2'd1;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0000_1000;
        start = 1'b1;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort hi", hi, 0);
        chk("abort lo", lo, 0);
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) sawDone = 1'b1;
        end
        chk("abort no done", sawDone, 0);

        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = '0;
                1: ry = 32'($urandom_range(1, 20));
                2: rx = 32'h8000_0000;
                3: ry = 32'hFFFF_FFFF;
                default: ;
            endcase
            doOp($sformatf("rand%0d op%0d", n, ro), ro, rx, ry, 1'b0, -1, -1);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
